// File: rtl/imem_responder_if.sv
// Instruction-fetch memory bus between the cache/TIM controller (master) and
// the on-chip word array responder (slave).
interface imem_responder_if;
  logic        mem_valid;
  logic        mem_fence;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_valid, mem_fence, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_valid, mem_fence, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory responder: serves reads, byte-strobed writes and fences
// from an on-chip word array with a fixed request-to-ready latency.
// Optional macro IMEM_RANDOM_STALL_EN adds 0..3 LFSR-driven extra wait cycles
// per request.
module imem_responder #(
  parameter int unsigned mem_depth   = 12,
  parameter int unsigned mem_latency = 1,
  parameter logic [31:0] mem_base    = 32'h0
) (
  input logic              clk,
  input logic              rst,
  imem_responder_if.slave  mem_bus
);

  localparam int unsigned num_words = 2 ** mem_depth;
  localparam logic [32:0] mem_span  = 33'(num_words) << 2;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                 state_q, state_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [31:0]            mem_q [num_words];

  logic [31:0]            offset;
  logic                   in_range;
  logic [mem_depth-1:0]   idx;
  logic                   accept;
  logic                   is_read;
  logic                   do_write;
  logic [4:0]             lat_eff;
  logic                   unused_instr;

  assign unused_instr = mem_bus.mem_instr;

  // Unsigned window check; the subtraction alone would wrap below the base.
  assign offset   = mem_bus.mem_addr - mem_base;
  assign in_range = (mem_bus.mem_addr >= mem_base) && ({1'b0, offset} < mem_span);
  assign idx      = offset[mem_depth+1:2];

  // Requests are only looked at when nothing is outstanding or in the ready cycle.
  assign accept   = mem_bus.mem_valid && (state_q != StWait);
  assign is_read  = !mem_bus.mem_fence && (mem_bus.mem_wstrb == 4'h0);
  assign do_write = accept && !rst && !mem_bus.mem_fence && (mem_bus.mem_wstrb != 4'h0) &&
                    in_range;

`ifdef IMEM_RANDOM_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;

  // The current LFSR value sets this request's extra stall, then it advances.
  assign lat_eff = 5'(mem_latency) + {3'b000, lfsr_q[1:0]};

  // Fibonacci LFSR, taps 8,6,5,4, stepped once per accepted request.
  always_comb begin
    lfsr_d = lfsr_q;
    if (accept) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  // Stall LFSR register, reseeded on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign lat_eff = 5'(mem_latency);
`endif

  // Next-state, latency counter and captured response data.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      StWait: begin
        if (cnt_q == 5'd1) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: begin
        if (accept) begin
          rdata_d = (is_read && in_range) ? mem_q[idx] : 32'h0;
          if (lat_eff == 5'd1) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = lat_eff - 5'd1;
          end
        end else begin
          state_d = StIdle;
        end
      end
    endcase
  end

  // Control registers; reset drops any outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Word array with byte strobes; deliberately not reset so code survives rst.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_bus.mem_wstrb[i]) begin
          mem_q[idx][8*i +: 8] <= mem_bus.mem_wdata[8*i +: 8];
        end
      end
    end
  end

  // rdata is forced to zero outside the ready cycle.
  assign mem_bus.mem_ready = (state_q == StResp);
  assign mem_bus.mem_rdata = (state_q == StResp) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: two instances (latency 2 and 1), a
// spec-level memory model, directed cases and randomized request bursts.
module tb_imem_responder;

  typedef struct {
    logic [31:0] data;
    int unsigned at;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        valid [2];
  logic        fence [2];
  logic        instr [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  wstrb [2];
  logic        ready [2];
  logic [31:0] rdata [2];

  imem_responder_if bus0 ();
  imem_responder_if bus1 ();

  assign bus0.mem_valid = valid[0];
  assign bus0.mem_fence = fence[0];
  assign bus0.mem_instr = instr[0];
  assign bus0.mem_addr  = addr[0];
  assign bus0.mem_wdata = wdata[0];
  assign bus0.mem_wstrb = wstrb[0];
  assign bus1.mem_valid = valid[1];
  assign bus1.mem_fence = fence[1];
  assign bus1.mem_instr = instr[1];
  assign bus1.mem_addr  = addr[1];
  assign bus1.mem_wdata = wdata[1];
  assign bus1.mem_wstrb = wstrb[1];
  assign ready[0] = bus0.mem_ready;
  assign rdata[0] = bus0.mem_rdata;
  assign ready[1] = bus1.mem_ready;
  assign rdata[1] = bus1.mem_rdata;

  imem_responder #(.mem_depth(12), .mem_latency(2), .mem_base(32'h0)) u_dut0 (
    .clk     (clk),
    .rst     (rst),
    .mem_bus (bus0)
  );

  imem_responder #(.mem_depth(12), .mem_latency(1), .mem_base(32'h0)) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .mem_bus (bus1)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          tests = 0;
  int          fails = 0;
  bit          mon_en = 1'b0;
  exp_t        exp_q [2][$];
  logic [31:0] mdl [2][4096];
  int unsigned avail [2];
  logic [7:0]  lfsr [2];

  function automatic int unsigned base_lat(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  // Reference behaviour: fence -> 0; write -> merge bytes if in range, 0;
  // read -> stored word if in range, else 0.
  function automatic logic [31:0] ref_access(input int k, input logic [31:0] a,
                                             input logic [31:0] wd, input logic [3:0] ws,
                                             input logic fnc);
    bit in_rng;
    int unsigned w;
    in_rng = (a < 32'h4000);
    w = a[13:2];
    if (fnc) return 32'h0;
    if (ws != 4'h0) begin
      if (in_rng) begin
        for (int b = 0; b < 4; b++) begin
          if (ws[b]) mdl[k][w][8*b +: 8] = wd[8*b +: 8];
        end
      end
      return 32'h0;
    end
    return in_rng ? mdl[k][w] : 32'h0;
  endfunction

  // Monitor: every ready must match the head of the queue in cycle and data.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        if (ready[k]) begin
          tests++;
          if (exp_q[k].size() == 0 || exp_q[k][0].at != cyc) begin
            fails++;
            $display("FAIL unexpected_ready dut%0d cyc=%0d: got ready=1, required ready=0",
                     k, cyc);
          end else begin
            exp_t e;
            e = exp_q[k].pop_front();
            if (rdata[k] !== e.data) begin
              fails++;
              $display("FAIL rdata dut%0d cyc=%0d: got %08h, required %08h",
                       k, cyc, rdata[k], e.data);
            end
          end
        end else begin
          tests++;
          if (rdata[k] !== 32'h0) begin
            fails++;
            $display("FAIL idle_rdata dut%0d cyc=%0d: got %08h, required 00000000",
                     k, cyc, rdata[k]);
          end
          if (exp_q[k].size() != 0 && exp_q[k][0].at <= cyc) begin
            tests++;
            fails++;
            $display("FAIL missing_ready dut%0d cyc=%0d: got ready=0, required ready=1",
                     k, cyc);
            void'(exp_q[k].pop_front());
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble(input int k);
    addr[k]  = $urandom;
    wdata[k] = $urandom;
    wstrb[k] = 4'($urandom);
    fence[k] = 1'($urandom);
    instr[k] = 1'($urandom);
  endtask

  // Present one request once the responder can accept it. With hold set,
  // valid stays high (with junk fields) until the next issue on this port.
  task automatic issue(input int k, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input logic fnc, input bit hold);
    logic [31:0] ed;
    int unsigned lat;
    while (cyc < avail[k]) step();
    valid[k] = 1'b1;
    addr[k]  = a;
    wdata[k] = wd;
    wstrb[k] = ws;
    fence[k] = fnc;
    instr[k] = 1'($urandom);
    ed  = ref_access(k, a, wd, ws, fnc);
    lat = base_lat(k);
`ifdef IMEM_RANDOM_STALL_EN
    lat = lat + int'(lfsr[k][1:0]);
    lfsr[k] = lfsr_next(lfsr[k]);
`endif
    exp_q[k].push_back('{data: ed, at: cyc + lat});
    avail[k] = cyc + lat;
    step();
    scramble(k);
    valid[k] = hold;
  endtask

  task automatic do_reset();
    valid[0] = 1'b0;
    valid[1] = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_q[k].delete();
      avail[k] = cyc;
      lfsr[k]  = 8'hA5;
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  ws;
    logic        fnc;
    int          k;
    int          n;
    int          op;

    for (int i = 0; i < 2; i++) begin
      valid[i] = 1'b0;
      scramble(i);
    end
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      avail[i] = cyc;
      lfsr[i]  = 8'hA5;
    end
    mon_en = 1'b1;
    step();

    // Preload words 0..127 of both arrays, valid held across each run.
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 128; w++) begin
        issue(i, 32'(w * 4) | 32'($urandom_range(0, 3)), $urandom, 4'hF, 1'b0, w != 127);
      end
    end

    // Full-word write then held-valid reads.
    issue(0, 32'h40, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1);
    issue(0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b1);
    issue(0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b0);

    // Byte-strobed merge.
    issue(0, 32'h40, 32'h11223344, 4'b0101, 1'b0, 1'b1);
    issue(0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b0);

    // Back-to-back burst on the single-cycle instance.
    issue(1, 32'h100, 32'h0, 4'h0, 1'b0, 1'b1);
    issue(1, 32'h104, 32'h0, 4'h0, 1'b0, 1'b1);
    issue(1, 32'h108, 32'h0, 4'h0, 1'b0, 1'b1);
    issue(1, 32'h10C, 32'h0, 4'h0, 1'b0, 1'b0);

    // Out of range: read returns 0, write must not alias onto word 0.
    issue(0, 32'h4000, 32'h0, 4'h0, 1'b0, 1'b0);
    issue(0, 32'h4000, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b0);
    issue(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);

    // Fence carrying write-looking fields must not touch the array.
    issue(0, 32'h40, 32'h12345678, 4'hF, 1'b1, 1'b0);
    issue(0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b0);

    // Reset one cycle after acceptance cancels the response; data survives.
    repeat (3) step();
    issue(0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b0);
    do_reset();
    repeat (4) step();
    issue(0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b0);
    issue(1, 32'h40, 32'h0, 4'h0, 1'b0, 1'b0);

    // Randomized bursts of mixed reads, writes, fences and out-of-range hits.
    for (int t = 0; t < 300; t++) begin
      k = $urandom_range(0, 1);
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        op  = $urandom_range(0, 7);
        a   = ($urandom_range(0, 7) == 0) ? (32'h4000 + $urandom) : 32'($urandom_range(0, 511));
        if (a < 32'h4000) a = a & 32'h1FF;
        fnc = (op == 0);
        ws  = (op == 1 || op == 2) ? 4'($urandom_range(1, 15)) : 4'h0;
        if (fnc) ws = 4'($urandom);
        issue(k, a, $urandom, ws, fnc, j != n - 1);
      end
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (24) step();
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (exp_q[i].size() != 0) begin
        fails++;
        $display("FAIL drain dut%0d: got %0d outstanding responses, required 0",
                 i, exp_q[i].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Responder (slave) end of the mem_in_type/mem_out_type instruction-fetch interface.
- Sits behind the instruction-side cache/TIM controller. Serves its refill, uncached-load and fence requests from an on-chip word array with a programmable access latency.
- Byte-strobed writes allow boot loaders and testbenches to preload code through the same port.

Parameters:
- mem_depth, 12, log2 of word count; array holds 2**mem_depth 32-bit words.
- mem_latency, 1, cycles from request acceptance to mem_ready; legal range 1..15.
- mem_base, 32'h0, byte base address of the array.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- mem_in  in  mem_in_type  request: mem_valid(1), mem_fence(1), mem_instr(1), mem_addr(32), mem_wdata(32), mem_wstrb(4).
- mem_out  out  mem_out_type  response: mem_rdata(32), mem_ready(1).

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to IDLE; latency counter cleared; any pending request is discarded and no mem_ready is issued for it.
  - mem_ready=0, mem_rdata=0.
  - Array contents are preserved across reset; only power-up initialisation zeroes the array.
- States:
  - IDLE: no request outstanding.
  - WAIT: request captured, counter running.
  - RESP: mem_ready=1 for exactly one cycle.
- Acceptance: mem_valid is sampled only in IDLE or RESP. In WAIT, mem_valid and all request fields are ignored. The initiator may hold mem_valid high across the wait; the responder does not require field stability after acceptance.
- Capture: addr, wdata, wstrb and fence are registered at the accepting edge. Word index = (mem_addr - mem_base)[mem_depth+1:2]; mem_addr[1:0] is ignored.
- In range means mem_base <= mem_addr < mem_base + 4*2**mem_depth, computed as an unsigned 32-bit comparison.
- Latency: a request accepted in cycle c gives mem_ready=1 in cycle c+mem_latency.
  - mem_latency=1: accept → RESP directly.
  - Otherwise: accept → WAIT; counter loads mem_latency-1; RESP when counter reaches 1.
- mem_rdata is valid only while mem_ready=1 and is 0 in every other cycle.
- Back-to-back: mem_valid=1 during RESP is accepted as a new request, so RESP→WAIT or RESP→RESP. With mem_latency=1, throughput is one word per cycle (burst refill). mem_valid=0 during RESP → IDLE.
- Read (mem_wstrb=0, mem_fence=0): array read at the accepting edge. Response = word at the index if in range, else 32'h0.
- Write (mem_wstrb≠0):
  - Bytes with mem_wstrb[i]=1 are written at the accepting edge; other bytes are unchanged.
  - Response rdata = 0, ready as normal. Out-of-range writes are dropped silently.
- Fence (mem_valid=1, mem_fence=1): no array access; addr/wdata ignored; ready after mem_latency with rdata=0.
- Ordering: a read accepted after a write to the same word returns the written data.
- mem_instr is accepted and otherwise ignored.

Optional Feature:
- Macro: IMEM_RANDOM_STALL_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) is seeded to 8'hA5 on reset and advances once per accepted request.
  - That request's latency is mem_latency + lfsr[1:0], giving 0..3 extra WAIT cycles.
  - A request that gets extra cycles always passes through WAIT, even when mem_latency=1.
  - Used to stress initiator wait handling.
- Undefined: no LFSR is present and latency is exactly mem_latency.

Test Plan:
- Preload at mem_latency=2: write 32'hDEADBEEF to 0x40 with wstrb=4'hF; then read 0x40 held valid → mem_ready exactly 2 cycles after each acceptance, rdata=32'hDEADBEEF, rdata=0 in all other cycles.
- Byte strobe: word 0x40=32'hDEADBEEF; write wdata=32'h11223344, wstrb=4'b0101; read 0x40 → 32'hDE22BE44.
- Burst at mem_latency=1: valid held high for 4 reads at 0x100,0x104,0x108,0x10C, address advanced combinationally in each ready cycle → mem_ready high for 4 consecutive cycles, data in order.
- Out of range (mem_depth=12, base 0): read 0x4000 → ready after latency with rdata=0; write to 0x4000 followed by read of 0x0000 → word 0 unchanged.
- Fence plus reset: fence → ready after mem_latency with rdata=0. Then read 0x40 with mem_latency=3 and assert rst one cycle after acceptance → no mem_ready; after reset, read 0x40 still returns 32'hDE22BE44.
- With IMEM_RANDOM_STALL_EN, mem_latency=1: 8 back-to-back reads → each latency in 1..4 and matches a reference LFSR seeded 8'hA5; data correct for every read.
